// File: rtl/rf_cmd_sequencer.sv
// rtl/rf_cmd_sequencer.sv - command FIFO and transaction sequencer in front of the MRF24J40 SPI engine
module rf_cmd_sequencer #(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 255
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_mode,
  input  logic [9:0] cmd_addr,
  input  logic [7:0] cmd_wdata,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [7:0] rsp_rdata,
  output logic       rsp_err,
  output logic       busy,
  input  logic       rf_ready,
  input  logic       rf_data_out,
  output logic       rf_c_en,
  output logic [1:0] rf_mode,
  output logic [9:0] rf_addr,
  output logic [7:0] rf_wdata
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = (TIMEOUT > 255) ? $clog2(TIMEOUT + 1) : 8;
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  typedef enum logic [2:0] {
    S_IDLE, S_ARM, S_ISSUE, S_START, S_XFER, S_DONE, S_ERR
  } state_t;

  state_t state, state_d;

  logic [19:0]   fifo_mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          push, pop, load;
  logic [CW-1:0] tcnt;
  logic          timeout_hit;
  logic [7:0]    shreg;

  assign cmd_ready   = (count != FULL_CNT);
  assign push        = cmd_valid && cmd_ready;
  assign busy        = (state != S_IDLE) || (count != '0);
  assign rf_c_en     = (state == S_ISSUE);
  assign timeout_hit = (TIMEOUT != 0) && (tcnt == CW'(TIMEOUT));

  // Command FIFO: entry is {mode, addr, wdata}; pointers wrap naturally at DEPTH
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) fifo_mem[i] <= '0;
    end else begin
      if (push) begin
        fifo_mem[wr_ptr] <= {cmd_mode, cmd_addr, cmd_wdata};
        wr_ptr           <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (!push && pop) count <= count - 1'b1;
    end
  end

  // State register and per-state cycle counter (restarts on every state change)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      tcnt  <= '0;
    end else begin
      state <= state_d;
      if (state_d != state) tcnt <= '0;
      else if (tcnt != '1)  tcnt <= tcnt + 1'b1;
    end
  end

  // Next-state logic; the head entry is latched when leaving IDLE and popped when ARM resolves
  always_comb begin
    state_d = state;
    pop     = 1'b0;
    load    = 1'b0;
    case (state)
      S_IDLE: begin
        if ((count != '0) && !rsp_valid) begin
          load    = 1'b1;
          state_d = S_ARM;
        end
      end
      S_ARM: begin
        if (rf_ready) begin
          pop     = 1'b1;
          state_d = S_ISSUE;
        end else if (timeout_hit) begin
          pop     = 1'b1;
          state_d = S_ERR;
        end
      end
      S_ISSUE: state_d = S_START;
      S_START: begin
        if (!rf_ready)        state_d = S_XFER;
        else if (timeout_hit) state_d = S_ERR;
      end
      S_XFER: begin
        if (rf_ready)         state_d = S_DONE;
        else if (timeout_hit) state_d = S_ERR;
      end
      S_DONE:  state_d = S_IDLE;
      S_ERR:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Engine holding registers: stay frozen for the whole transaction since the engine samples them live
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rf_mode  <= '0;
      rf_addr  <= '0;
      rf_wdata <= '0;
    end else if (load) begin
      {rf_mode, rf_addr, rf_wdata} <= fifo_mem[rd_ptr];
    end
  end

  // Serial read capture: only the final 8 bits before rf_ready rises survive
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg <= '0;
    end else if ((state == S_XFER) && !rf_ready) begin
      shreg <= {shreg[6:0], rf_data_out};
    end
  end

  // Response holding register: set on DONE/ERR, released by the host handshake
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else if (state == S_DONE) begin
      rsp_valid <= 1'b1;
      rsp_rdata <= rf_mode[0] ? 8'h00 : shreg;
      rsp_err   <= 1'b0;
    end else if (state == S_ERR) begin
      rsp_valid <= 1'b1;
      rsp_rdata <= 8'h00;
      rsp_err   <= 1'b1;
    end else if (rsp_valid && rsp_ready) begin
      rsp_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_rf_cmd_sequencer.sv
// tb/tb_rf_cmd_sequencer.sv - scoreboard bench with a behavioural SPI engine model
module tb_rf_cmd_sequencer;

  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 16;

  logic       clk, rst_n;
  logic       cmd_valid, cmd_ready;
  logic [1:0] cmd_mode;
  logic [9:0] cmd_addr;
  logic [7:0] cmd_wdata;
  logic       rsp_valid, rsp_ready, rsp_err;
  logic [7:0] rsp_rdata;
  logic       busy, rf_ready, rf_data_out, rf_c_en;
  logic [1:0] rf_mode;
  logic [9:0] rf_addr;
  logic [7:0] rf_wdata;

  rf_cmd_sequencer #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_mode(cmd_mode),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .busy(busy), .rf_ready(rf_ready), .rf_data_out(rf_data_out), .rf_c_en(rf_c_en),
    .rf_mode(rf_mode), .rf_addr(rf_addr), .rf_wdata(rf_wdata)
  );

  typedef struct packed {
    logic       dead;
    logic [1:0] mode;
    logic [9:0] addr;
    logic [7:0] wdata;
  } eng_t;

  typedef struct packed {
    logic [7:0] rdata;
    logic       err;
  } rsp_t;

  eng_t eng_q[$];
  rsp_t exp_q[$];
  int   checks   = 0;
  int   errors   = 0;
  int   c_en_cnt = 0;
  int   rr_mode  = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  function automatic logic [7:0] rd_byte(input logic [9:0] a);
    return a[7:0] ^ 8'h3C;
  endfunction

  // Engine model: on each start strobe, either ignore it (dead) or run an address phase then 8 data bits MSB first
  initial begin
    eng_t       e;
    logic [7:0] b;
    int         g, bad;
    bit         abort;
    rf_ready    = 1'b1;
    rf_data_out = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (rst_n && rf_c_en) begin
        c_en_cnt++;
        if (eng_q.size() == 0) begin
          check("issue_unexpected", 1, 0);
        end else begin
          e = eng_q.pop_front();
          check("issue_mode", rf_mode, e.mode);
          check("issue_addr", rf_addr, e.addr);
          check("issue_wdata", rf_wdata, e.wdata);
          if (!e.dead) begin
            g     = 2 + $urandom_range(0, 4);
            b     = e.mode[0] ? 8'($urandom) : rd_byte(e.addr);
            bad   = 0;
            abort = 0;
            for (int j = 0; j < g + 8; j++) begin
              if (j > 0) begin
                @(posedge clk); #1;
                if (!rst_n) begin
                  abort = 1;
                  break;
                end
                if (rf_addr !== e.addr || rf_wdata !== e.wdata || rf_mode !== e.mode || rf_c_en) bad++;
              end
              rf_ready    = 1'b0;
              rf_data_out = (j < g) ? 1'($urandom) : b[7 - (j - g)];
            end
            if (!abort) begin
              @(posedge clk); #1;
              if (rst_n) check("hold_stable", bad, 0);
            end
            rf_ready = 1'b1;
          end
        end
      end
    end
  end

  // Host response acceptance: 0 random, 1 held low, 2 accept after 5 cycles of rsp_valid
  initial begin
    int vcnt;
    vcnt      = 0;
    rsp_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (rsp_valid && !rsp_ready) vcnt++;
      else vcnt = 0;
      case (rr_mode)
        0:       rsp_ready = 1'($urandom);
        1:       rsp_ready = 1'b0;
        default: rsp_ready = rsp_valid && (vcnt >= 5);
      endcase
    end
  end

  // Monitor: pops the scoreboard on each response handshake and checks strobe spacing
  initial begin
    rsp_t x;
    logic prev;
    prev = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev = 1'b0;
      end else begin
        if (rf_c_en) check("c_en_single", prev, 0);
        prev = rf_c_en;
        if (rsp_valid && rsp_ready) begin
          if (exp_q.size() == 0) begin
            check("rsp_unexpected", 1, 0);
          end else begin
            x = exp_q.pop_front();
            check("rsp_rdata", rsp_rdata, x.rdata);
            check("rsp_err", rsp_err, x.err);
          end
        end
      end
    end
  end

  task automatic push(input logic [1:0] m, input logic [9:0] a, input logic [7:0] d, input logic dead);
    rsp_t r;
    eng_t e;
    int   n;
    n       = 0;
    r.err   = dead;
    r.rdata = (dead || m[0]) ? 8'h00 : rd_byte(a);
    exp_q.push_back(r);
    e.dead  = dead;
    e.mode  = m;
    e.addr  = a;
    e.wdata = d;
    eng_q.push_back(e);
    cmd_valid = 1'b1;
    cmd_mode  = m;
    cmd_addr  = a;
    cmd_wdata = d;
    while (!cmd_ready && n < 2000) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 2000) check("push_timeout", 0, 1);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while ((busy || rsp_valid || exp_q.size() != 0) && n < 3000) begin
      @(posedge clk); #1;
      n++;
    end
    check(name, n < 3000, 1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_cmd_ready"}, cmd_ready, 1);
    check({tag, "_rsp_valid"}, rsp_valid, 0);
    check({tag, "_rsp_rdata"}, rsp_rdata, 0);
    check({tag, "_rsp_err"}, rsp_err, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_rf_c_en"}, rf_c_en, 0);
    check({tag, "_rf_mode"}, rf_mode, 0);
    check({tag, "_rf_addr"}, rf_addr, 0);
    check({tag, "_rf_wdata"}, rf_wdata, 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, c0;
    logic [1:0] m;
    logic [9:0] a;
    rst_n     = 1'b0;
    cmd_valid = 1'b0;
    cmd_mode  = '0;
    cmd_addr  = '0;
    cmd_wdata = '0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("rst");
    rst_n = 1'b1;
    @(posedge clk); #1;
    check_reset_outputs("post_rst");

    // Short write 0x15 <- 0xA5, with push-to-strobe latency
    rr_mode = 0;
    c0 = c_en_cnt;
    push(2'b01, 10'h015, 8'hA5, 1'b0);
    n = 1;
    while (!rf_c_en && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check("latency", n, 3);
    wait_idle("short_wr_done");
    check("short_wr_pulses", c_en_cnt - c0, 1);

    // Long read 0x200 returns 0x3C
    c0 = c_en_cnt;
    push(2'b10, 10'h200, 8'h00, 1'b0);
    wait_idle("long_rd_done");
    check("long_rd_pulses", c_en_cnt - c0, 1);

    // Response held: FIFO fills behind it and nothing issues until it is accepted
    rr_mode = 1;
    push(2'b00, 10'h001, 8'h00, 1'b0);
    n = 0;
    while (!rsp_valid && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    check("first_rsp_seen", rsp_valid, 1);
    c0 = c_en_cnt;
    for (int i = 0; i < DEPTH; i++) push(2'b10, 10'(10'h100 + i * 7), 8'h00, 1'b0);
    check("fifo_full_ready", cmd_ready, 0);
    check("fifo_full_busy", busy, 1);
    repeat (10) @(posedge clk);
    #1;
    check("no_issue_while_rsp", c_en_cnt - c0, 0);
    rr_mode = 2;
    push(2'b01, 10'h033, 8'h5A, 1'b0);
    wait_idle("fill_drain");
    check("fill_pulses", c_en_cnt - c0, DEPTH + 1);

    // Dead engine: START times out, then the following command proceeds
    rr_mode = 0;
    c0 = c_en_cnt;
    push(2'b00, 10'h00A, 8'h00, 1'b1);
    push(2'b11, 10'h155, 8'h77, 1'b0);
    wait_idle("timeout_done");
    check("timeout_pulses", c_en_cnt - c0, 2);

    // Randomized traffic
    for (int i = 0; i < 24; i++) begin
      m = 2'($urandom);
      a = 10'($urandom);
      if (!m[1]) a[9:6] = 4'h0;
      push(m, a, 8'($urandom), $urandom_range(0, 7) == 0);
    end
    wait_idle("random_done");

    // Reset during a transfer
    push(2'b10, 10'h1F3, 8'h00, 1'b0);
    n = 0;
    while (rf_ready && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    repeat (3) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("mid_rst");
    exp_q.delete();
    eng_q.delete();
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("after_rst_busy", busy, 0);
    check("after_rst_rsp_valid", rsp_valid, 0);
    push(2'b00, 10'h02E, 8'h00, 1'b0);
    wait_idle("after_rst_done");

    check("exp_q_empty", exp_q.size(), 0);
    check("eng_q_empty", eng_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
